// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, access sizes and FSM states for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] encodes the access size; funct3[2] selects zero-extension
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - data-memory req/gnt + rvalid bus between the M stage and memory
interface lsu_mem_stage_if;

  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_gnt;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;

  modport master (
    output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
    input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );

  modport slave (
    input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
    output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );

endinterface

// File: rtl/lsu_byte_align.sv
// rtl/lsu_byte_align.sv - byte-lane steering for stores, lane select/extension for loads, alignment check
module lsu_byte_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_fmt,
  output logic        misalign
);

  logic [31:0] lane;

  // Shift the addressed byte/half down to bit 0 before extension
  assign lane = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be       = 4'b0000;
    wdata    = 32'h0;
    ld_fmt   = 32'h0;
    misalign = 1'b0;
    case (funct3[1:0])
      SZ_B: begin
        be     = BE_B << addr_lo;
        wdata  = {4{st_data[7:0]}};
        ld_fmt = funct3[2] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        be       = BE_H << addr_lo;
        wdata    = {2{st_data[15:0]}};
        ld_fmt   = funct3[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        misalign = addr_lo[0];
      end
      SZ_W: begin
        be       = BE_W;
        wdata    = st_data;
        ld_fmt   = rdata;
        misalign = |addr_lo;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - M-stage load/store unit: one data-memory access per instruction, stalling until done
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [31:0]           alu_data_M,
  input  logic [31:0]           st_data_M,
  input  logic [2:0]            funct3_M,
  input  logic                  mem_wren_M,
  input  logic                  mem_rden_M,
  lsu_mem_stage_if.master       dmem,
  output logic [31:0]           ld_data_M,
  output logic                  o_ld_valid,
  output logic                  o_stall_M,
  output logic                  o_misalign,
  output logic                  o_bus_err
);

  lsu_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q, wdata_q, ld_data_q;
  logic [3:0]       be_q;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic             we_q, load_q, err_q;

  logic        access, idle, launch, timeout;
  logic [1:0]  sel_lo;
  logic [2:0]  sel_f3;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld;
  logic        al_mis;

  assign access  = mem_wren_M | mem_rden_M;
  assign idle    = (state_q == IDLE);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // The aligner sees live M-stage fields while idle and the latched ones during the access
  assign sel_lo = idle ? alu_data_M[1:0] : lo_q;
  assign sel_f3 = idle ? funct3_M : f3_q;

  lsu_byte_align u_align (
    .addr_lo  (sel_lo),
    .funct3   (sel_f3),
    .st_data  (st_data_M),
    .rdata    (dmem.i_dmem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_fmt   (al_ld),
    .misalign (al_mis)
  );

  assign launch = idle & access & ~al_mis;

  always_comb begin
    state_d    = state_q;
    o_stall_M  = 1'b0;
    o_misalign = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (al_mis) begin
            o_misalign = 1'b1;
          end else begin
            o_stall_M = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        o_stall_M = 1'b1;
        if (dmem.i_dmem_gnt) state_d = RESP;
      end
      RESP: begin
        o_stall_M = 1'b1;
        if (dmem.i_dmem_rvalid || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      we_q      <= 1'b0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      f3_q      <= 3'h0;
      lo_q      <= 2'h0;
      ld_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        addr_q  <= {alu_data_M[31:2], 2'b00};
        be_q    <= al_be;
        wdata_q <= mem_wren_M ? al_wdata : 32'h0;
        we_q    <= mem_wren_M;
        load_q  <= ~mem_wren_M;
        f3_q    <= funct3_M;
        lo_q    <= alu_data_M[1:0];
        err_q   <= 1'b0;
      end
      if (state_q == REQ && dmem.i_dmem_gnt) cnt_q <= '0;
      // A response in the final timeout cycle still wins over the error
      if (state_q == RESP) begin
        cnt_q <= cnt_q + 1'b1;
        if (dmem.i_dmem_rvalid) begin
          if (load_q) ld_data_q <= al_ld;
        end else if (timeout) begin
          ld_data_q <= 32'h0;
          err_q     <= 1'b1;
        end
      end
    end
  end

  assign dmem.o_dmem_req   = (state_q == REQ);
  assign dmem.o_dmem_we    = we_q;
  assign dmem.o_dmem_addr  = addr_q;
  assign dmem.o_dmem_be    = be_q;
  assign dmem.o_dmem_wdata = wdata_q;

  assign ld_data_M  = ld_data_q;
  assign o_ld_valid = (state_q == DONE) & load_q & ~err_q;
  assign o_bus_err  = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage with a size/lane reference model
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] alu = 32'h0, sd = 32'h0;
  logic [2:0]  f3 = 3'h0;
  logic        wren = 1'b0, rden = 1'b0;
  logic [31:0] ld_data;
  logic        ld_valid, stall, misalign, bus_err;

  lsu_mem_stage_if bus();

  lsu_mem_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .alu_data_M (alu),
    .st_data_M  (sd),
    .funct3_M   (f3),
    .mem_wren_M (wren),
    .mem_rden_M (rden),
    .dmem       (bus),
    .ld_data_M  (ld_data),
    .o_ld_valid (ld_valid),
    .o_stall_M  (stall),
    .o_misalign (misalign),
    .o_bus_err  (bus_err)
  );

  int checks = 0;
  int errors = 0;

  // Observations gathered by run_access for the calling test to judge
  int          o_stall_cyc, o_req_cyc, o_resp_cyc, o_mis, o_ldv, o_err;
  bit          o_unstable, o_hung;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_be;
  logic        o_we;
  logic [31:0] exp_hold;

  function automatic bit m_mis(input logic [2:0] fn, input logic [31:0] a);
    int sz = int'(fn[1:0]);
    if (sz == 3) return 1'b1;
    return (a % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] fn, input logic [31:0] a);
    int n = 1 << fn[1:0];
    int mask = (1 << n) - 1;
    return 4'((mask << (a % 4)) & 15);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] fn, input logic [31:0] s);
    logic [31:0] w;
    int n = 1 << fn[1:0];
    for (int i = 0; i < 4; i++) w[8*i +: 8] = s[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] r);
    int n = 1 << fn[1:0];
    longint v = longint'(r >> (8 * (a % 4))) & ((64'sd1 << (8 * n)) - 1);
    if (!fn[2] && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
    return 32'(v);
  endfunction

  task automatic run_access(input bit is_st, input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] s, input logic [31:0] r,
                            input int gdly, input int rdly, input bit noise);
    int  req_cnt, resp_cnt;
    bit  granted;
    o_stall_cyc = 0; o_req_cyc = 0; o_resp_cyc = 0; o_mis = 0; o_ldv = 0; o_err = 0;
    o_unstable = 0; o_hung = 1; o_ld = 32'h0;
    o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0; o_we = 1'b0;
    req_cnt = 0; resp_cnt = 0; granted = 0;
    @(negedge clk);
    alu = a; sd = s; f3 = fn; wren = is_st; rden = ~is_st;
    bus.i_dmem_rdata = r; bus.i_dmem_gnt = 1'b0; bus.i_dmem_rvalid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (stall)    o_stall_cyc++;
      if (misalign) o_mis++;
      if (ld_valid) o_ldv++;
      if (bus_err)  o_err++;
      bus.i_dmem_gnt = 1'b0;
      bus.i_dmem_rvalid = 1'b0;
      if (bus.o_dmem_req) begin
        if (req_cnt == 0) begin
          o_addr = bus.o_dmem_addr; o_be = bus.o_dmem_be;
          o_we = bus.o_dmem_we; o_wdata = bus.o_dmem_wdata;
        end else if ({o_addr, o_be, o_we, o_wdata} !==
                     {bus.o_dmem_addr, bus.o_dmem_be, bus.o_dmem_we, bus.o_dmem_wdata}) begin
          o_unstable = 1;
        end
        o_req_cyc++;
        if (req_cnt == gdly) begin
          bus.i_dmem_gnt = 1'b1;
          granted = 1;
        end else if (noise) begin
          bus.i_dmem_rvalid = 1'($urandom_range(0, 1));
        end
        req_cnt++;
      end else if (stall && granted) begin
        o_resp_cyc++;
        if (rdly >= 0 && resp_cnt == rdly) bus.i_dmem_rvalid = 1'b1;
        resp_cnt++;
      end
      if (!stall) begin
        o_ld = ld_data;
        o_hung = 0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    wren = 1'b0; rden = 1'b0;
    bus.i_dmem_gnt = 1'b0; bus.i_dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_dmem_gnt = 1'b0; bus.i_dmem_rvalid = 1'b0; bus.i_dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.o_dmem_req, bus.o_dmem_we, bus.o_dmem_be} !== 6'h0) begin
      errors++; $display("FAIL reset_bus_ctrl: got req/we/be=%b required 0", {bus.o_dmem_req, bus.o_dmem_we, bus.o_dmem_be});
    end
    checks++;
    if ({bus.o_dmem_addr, bus.o_dmem_wdata, ld_data} !== 96'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h ld=%h required 0", bus.o_dmem_addr, bus.o_dmem_wdata, ld_data);
    end
    checks++;
    if ({ld_valid, stall, misalign, bus_err} !== 4'h0) begin
      errors++; $display("FAIL reset_flags: got %b required 0000", {ld_valid, stall, misalign, bus_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hold = 32'h0;
  endtask

  task automatic test_lw();
    run_access(1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
    checks++;
    if (o_hung) begin errors++; $display("FAIL lw_hang: access never completed"); end
    checks++;
    if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin
      errors++; $display("FAIL lw_bus: addr=%h be=%b we=%b required 100/1111/0", o_addr, o_be, o_we);
    end
    checks++;
    if (o_stall_cyc != 3) begin errors++; $display("FAIL lw_stall: got %0d cycles required 3", o_stall_cyc); end
    checks++;
    if (o_ld !== 32'hDEADBEEF || o_ldv != 1) begin
      errors++; $display("FAIL lw_data: ld=%h valid_pulses=%0d required deadbeef/1", o_ld, o_ldv);
    end
    exp_hold = 32'hDEADBEEF;
  endtask

  task automatic test_lb_lbu();
    run_access(1'b0, F3_B, 32'h203, 32'h0, 32'h80112233, 0, 0, 1'b0);
    checks++;
    if (o_be !== 4'b1000 || o_addr !== 32'h200) begin
      errors++; $display("FAIL lb_bus: be=%b addr=%h required 1000/200", o_be, o_addr);
    end
    checks++;
    if (o_ld !== 32'hFFFFFF80 || o_ldv != 1) begin
      errors++; $display("FAIL lb_data: ld=%h valid=%0d required ffffff80/1", o_ld, o_ldv);
    end
    run_access(1'b0, F3_BU, 32'h203, 32'h0, 32'h80112233, 0, 0, 1'b0);
    checks++;
    if (o_ld !== 32'h00000080 || o_ldv != 1) begin
      errors++; $display("FAIL lbu_data: ld=%h valid=%0d required 00000080/1", o_ld, o_ldv);
    end
    exp_hold = 32'h00000080;
  endtask

  task automatic test_sh_delayed();
    run_access(1'b1, F3_H, 32'h302, 32'h0000ABCD, 32'h0, 3, 0, 1'b1);
    checks++;
    if (o_req_cyc != 4 || o_unstable) begin
      errors++; $display("FAIL sh_req_hold: req cycles=%0d unstable=%0d required 4/0", o_req_cyc, o_unstable);
    end
    checks++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_we !== 1'b1 || o_addr !== 32'h300) begin
      errors++; $display("FAIL sh_bus: be=%b wdata=%h we=%b addr=%h required 1100/abcdabcd/1/300", o_be, o_wdata, o_we, o_addr);
    end
    checks++;
    if (o_ldv != 0 || o_ld !== exp_hold) begin
      errors++; $display("FAIL sh_no_load: valid=%0d ld=%h required 0/%h", o_ldv, o_ld, exp_hold);
    end
  endtask

  task automatic test_misalign();
    run_access(1'b0, F3_W, 32'h101, 32'h0, 32'h12345678, 0, 0, 1'b0);
    checks++;
    if (o_mis != 1 || o_req_cyc != 0 || o_stall_cyc != 0) begin
      errors++; $display("FAIL misalign: pulses=%0d req=%0d stall=%0d required 1/0/0", o_mis, o_req_cyc, o_stall_cyc);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, F3_H, 32'h10, 32'h0, 32'h5555AAAA, 0, -1, 1'b0);
    checks++;
    if (o_hung || o_resp_cyc != 16 || o_err != 1) begin
      errors++; $display("FAIL timeout: hung=%0d resp=%0d err=%0d required 0/16/1", o_hung, o_resp_cyc, o_err);
    end
    checks++;
    if (o_ld !== 32'h0 || o_ldv != 0 || o_stall_cyc != 18) begin
      errors++; $display("FAIL timeout_data: ld=%h valid=%0d stall=%0d required 0/0/18", o_ld, o_ldv, o_stall_cyc);
    end
    exp_hold = 32'h0;
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: stall=%b err=%b required 0/0", stall, bus_err);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    run_access(1'b0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0);
    @(negedge clk);
    alu = 32'h40; f3 = F3_W; rden = 1'b1; bus.i_dmem_rdata = 32'h11111111;
    @(negedge clk); bus.i_dmem_gnt = 1'b1;
    @(negedge clk); bus.i_dmem_gnt = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b1 || bus.o_dmem_req !== 1'b0) begin
      errors++; $display("FAIL mid_in_resp: stall=%b req=%b required 1/0", stall, bus.o_dmem_req);
    end
    rst_n = 1'b0; rden = 1'b0;
    #1;
    checks++;
    if ({bus.o_dmem_req, stall, bus.o_dmem_be, ld_data, bus.o_dmem_addr} !== 70'h0) begin
      errors++; $display("FAIL mid_reset_out: req=%b stall=%b be=%b ld=%h addr=%h required 0", bus.o_dmem_req, stall, bus.o_dmem_be, ld_data, bus.o_dmem_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus.i_dmem_rvalid = 1'b1;
    @(negedge clk); bus.i_dmem_rvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ld_valid || stall || bus.o_dmem_req || ld_data !== 32'h0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_late_rvalid: %0d bad cycles required 0", bad); end
    run_access(1'b0, F3_W, 32'h44, 32'h0, 32'h0BADC0DE, 1, 1, 1'b0);
    checks++;
    if (o_ld !== 32'h0BADC0DE || o_ldv != 1 || o_stall_cyc != 5) begin
      errors++; $display("FAIL mid_next_lw: ld=%h valid=%0d stall=%0d required 0badc0de/1/5", o_ld, o_ldv, o_stall_cyc);
    end
    exp_hold = 32'h0BADC0DE;
  endtask

  task automatic test_random();
    logic [2:0]  fn_tab [6] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU, 3'b011};
    logic [2:0]  fn;
    logic [31:0] a, s, r, exp_ld;
    bit          st;
    int          gdly, rdly, exp_stall;
    for (int it = 0; it < 40; it++) begin
      st = 1'($urandom_range(0, 1));
      fn = fn_tab[$urandom_range(0, 5)];
      if (st) fn[2] = 1'b0;
      a = $urandom; s = $urandom; r = $urandom;
      gdly = $urandom_range(0, 3);
      rdly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      run_access(st, fn, a, s, r, gdly, rdly, 1'b1);
      checks++;
      if (m_mis(fn, a)) begin
        if (o_mis != 1 || o_req_cyc != 0 || o_stall_cyc != 0 || o_ld !== exp_hold) begin
          errors++; $display("FAIL rnd_mis[%0d]: f3=%b a=%h mis=%0d req=%0d stall=%0d ld=%h", it, fn, a, o_mis, o_req_cyc, o_stall_cyc, o_ld);
        end
      end else begin
        exp_stall = 2 + gdly + ((rdly >= 0) ? rdly + 1 : 16);
        exp_ld = (rdly < 0) ? 32'h0 : (st ? exp_hold : m_ld(fn, a, r));
        if (o_hung || o_unstable || o_mis != 0 || o_stall_cyc != exp_stall ||
            o_addr !== {a[31:2], 2'b00} || o_be !== m_be(fn, a) || o_we !== st ||
            (st && o_wdata !== m_wdata(fn, s)) ||
            o_ldv != int'(!st && rdly >= 0) || o_err != int'(rdly < 0) || o_ld !== exp_ld) begin
          errors++;
          $display("FAIL rnd_acc[%0d]: st=%0d f3=%b a=%h g=%0d r=%0d stall=%0d/%0d be=%b/%b wd=%h/%h ld=%h/%h ldv=%0d err=%0d",
                   it, st, fn, a, gdly, rdly, o_stall_cyc, exp_stall, o_be, m_be(fn, a),
                   o_wdata, m_wdata(fn, s), o_ld, exp_ld, o_ldv, o_err);
        end
        exp_hold = exp_ld;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh_delayed();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
